cue_strike_controller: RTL and testbench
========================================

# cue_strike_controller

Player-facing shot controller directly upstream of the ball motion block. It converts keyboard levels into a cue angle and a charged shot power, then issues a single-cycle velocity write (velocityWriteEnable, velocity X/Y) to the cue ball. It then locks out further shots until the ball has come to rest.

## Interface
Parameters:
- ROTATE_FRAMES, 4: frames per one-step angle change while a rotate key is held.
- CHARGE_FRAMES, 3: frames per power increment while charging.
- MAX_POWER, 63: power saturation value (≤63).
- SETTLE_FRAMES, 2: minimum frames spent in WAIT_MOVE.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per video frame.
- keyRotateCW  in  1  synchronized level; rotate angle +1.
- keyRotateCCW  in  1  synchronized level; rotate angle −1.
- keyCharge  in  1  synchronized level; hold to charge, release to shoot.
- ballStopped  in  1  cue ball at rest.
- velocityWriteEnable  out  1  one-cycle shot strobe.
- outVelocityX  out  11 signed  shot velocity X, units 1/64 px/frame.
- outVelocityY  out  11 signed  shot velocity Y (+ = down).
- cueAngle  out  5  direction index 0..31; 0 = +X, 8 = +Y.
- cuePower  out  6  current charge, 0..MAX_POWER.
- cueVisible  out  1  draw cue overlay.

## Operation
- States: AIM, CHARGE, FIRE, WAIT_MOVE. Reset → AIM.
- Keys and ballStopped are acted on only in cycles with startOfFrame=1, except the FIRE exit.
- AIM (cueVisible=1):
  - One rotate key held: frame counter runs; every ROTATE_FRAMES-th frame angle ±1, mod 32 (31+1→0, 0−1→31).
  - Both or neither held: counter cleared, angle unchanged.
  - keyCharge=1 and ballStopped=1: → CHARGE, power=0, charge counter cleared.
  - keyCharge=1 with ballStopped=0: ignored.
- CHARGE (cueVisible=1): rotation ignored.
  - Every CHARGE_FRAMES-th frame, power+1, saturating at MAX_POWER.
  - keyCharge=0 and power=0: → AIM, no strobe.
  - keyCharge=0 and power>0: latch velocity, → FIRE.
- FIRE: velocityWriteEnable=1 for exactly one clk, then unconditional → WAIT_MOVE.
- WAIT_MOVE (cueVisible=0): counts frames. At a startOfFrame with count ≥ SETTLE_FRAMES and ballStopped=1 → AIM, power cleared to 0.
- Velocity arithmetic:
  - dirX/dirY = round(64·cos/sin(2πk/32)), signed 8-bit. Examples: k=0 (64,0); k=4 (45,45); k=8 (0,64); k=16 (−64,0).
  - vel = (power·dir) >>> 2, arithmetic shift (floor), 13-bit intermediate.
  - Range ±1008; fits 11 bits without clipping.
- Reset values: velocityWriteEnable=0, outVelocityX/Y=0, cueAngle=0, cuePower=0, cueVisible=1.
- Reset asserted mid-operation returns every register to its reset value immediately. No strobe is emitted.

## Timing
- The CHARGE→FIRE transition happens on the clk edge of the release frame. velocityWriteEnable is high during the following cycle.
- outVelocityX/Y are registered. They are valid in the strobe cycle and held until the next FIRE.
- Earliest re-aim is SETTLE_FRAMES frames after FIRE. This covers the one-cycle lag before ballStopped reflects the new velocity.
- startOfFrame coinciding with the FIRE cycle is ignored by the WAIT_MOVE counter.

## Structure
- Package cue_pkg:
  - state enum (AIM, CHARGE, FIRE, WAIT_MOVE)
  - DIR_SCALE=64, ANGLE_STEPS=32, VEL_SHIFT=2
  - 32-entry dirX/dirY constant arrays
- Sub-module cue_direction_rom: combinational angle → (dirX, dirY) lookup from the package tables.
- Top module: FSM, frame counters, power register, and the multiply/shift.

## Test plan
- Reset then release with no keys → cueAngle=0, cuePower=0, cueVisible=1, velocityWriteEnable=0, velocities 0.
- CCW held 4 frames (ROTATE_FRAMES=4) from angle 0 → cueAngle=31. CW held 32 frames → cueAngle=7. Both keys held → unchanged.
- Angle 0, ballStopped=1, charge held 30 frames then released → power=10, one-cycle strobe with X=160, Y=0. Then cueVisible=0.
- Angle 20 (dir (−45,−45)), power 10 → X=Y=−113 (floor of −112.5). Angle 16, charge held 300 frames → power saturates at 63, X=−1008, Y=0.
- ballStopped=0 in AIM with charge pressed → remains AIM, no strobe. In WAIT_MOVE with ballStopped=1 → returns to AIM after exactly 2 frames, power=0.
- Charge tapped and released before first increment → back to AIM, no strobe. resetN pulled low mid-CHARGE → AIM, power 0, no strobe.

Source files
------------

// File: rtl/cue_pkg.sv
// Shared types and constants for the cue strike controller: FSM state type,
// direction scaling, and the 32-step unit-circle tables (scaled by 64).
package cue_pkg;

  typedef enum logic [1:0] {
    ST_AIM       = 2'd0,
    ST_CHARGE    = 2'd1,
    ST_FIRE      = 2'd2,
    ST_WAIT_MOVE = 2'd3
  } cue_state_e;

  localparam int DIR_SCALE   = 64;
  localparam int ANGLE_STEPS = 32;
  localparam int VEL_SHIFT   = 2;

  // round(64*cos(2*pi*k/32)), k = 0..31
  localparam logic signed [7:0] DIR_X [ANGLE_STEPS] = '{
     8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
     8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
    -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12,
     8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63
  };

  // round(64*sin(2*pi*k/32)), k = 0..31; positive Y points down the screen
  localparam logic signed [7:0] DIR_Y [ANGLE_STEPS] = '{
     8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63,
     8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
     8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
    -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12
  };

endpackage

// File: rtl/cue_direction_rom.sv
// Combinational lookup: cue angle index -> scaled unit direction vector.
module cue_direction_rom
  import cue_pkg::*;
(
  input  logic [4:0]        i_angle,
  output logic signed [7:0] o_dir_x,
  output logic signed [7:0] o_dir_y
);

  assign o_dir_x = DIR_X[i_angle];
  assign o_dir_y = DIR_Y[i_angle];

endmodule

// File: rtl/cue_strike_controller.sv
// Shot controller: turns key levels into a cue angle and charged power,
// emits a one-cycle velocity write to the cue ball, then locks out new
// shots until the ball has settled.
module cue_strike_controller
  import cue_pkg::*;
#(
  parameter int ROTATE_FRAMES = 4,
  parameter int CHARGE_FRAMES = 3,
  parameter int MAX_POWER     = 63,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyRotateCW,
  input  logic               keyRotateCCW,
  input  logic               keyCharge,
  input  logic               ballStopped,
  output logic               velocityWriteEnable,
  output logic signed [10:0] outVelocityX,
  output logic signed [10:0] outVelocityY,
  output logic [4:0]         cueAngle,
  output logic [5:0]         cuePower,
  output logic               cueVisible
);

  // Full 6-bit power range times DIR_SCALE, plus a sign bit.
  localparam int PROD_W = $clog2(64 * DIR_SCALE) + 1;

  localparam logic [7:0] ROT_LAST  = 8'(ROTATE_FRAMES - 1);
  localparam logic [7:0] CHG_LAST  = 8'(CHARGE_FRAMES - 1);
  localparam logic [5:0] PWR_MAX   = 6'(MAX_POWER);
  localparam logic [8:0] SETTLE_TH = 9'(SETTLE_FRAMES);

  cue_state_e         r_state;
  logic [7:0]         r_rot_cnt;
  logic [7:0]         r_chg_cnt;
  logic [7:0]         r_settle_cnt;
  logic [4:0]         r_angle;
  logic [5:0]         r_power;
  logic signed [10:0] r_vel_x;
  logic signed [10:0] r_vel_y;

  logic signed [7:0]        w_dir_x;
  logic signed [7:0]        w_dir_y;
  logic signed [PROD_W-1:0] w_pow_s;
  logic signed [PROD_W-1:0] w_prod_x;
  logic signed [PROD_W-1:0] w_prod_y;
  logic                     w_rot_one;
  logic                     w_fire_go;
  logic                     w_settled;

  cue_direction_rom u_dir_rom (
    .i_angle (r_angle),
    .o_dir_x (w_dir_x),
    .o_dir_y (w_dir_y)
  );

  // Power is unsigned, so zero-extend it; the size casts sign-extend the directions.
  assign w_pow_s   = PROD_W'({1'b0, r_power});
  assign w_prod_x  = w_pow_s * PROD_W'(w_dir_x);
  assign w_prod_y  = w_pow_s * PROD_W'(w_dir_y);

  assign w_rot_one = keyRotateCW ^ keyRotateCCW;
  assign w_fire_go = (r_state == ST_CHARGE) && startOfFrame && !keyCharge && (r_power != 6'd0);
  // Counts the current frame too, so the Nth frame after FIRE can release.
  assign w_settled = ({1'b0, r_settle_cnt} + 9'd1) >= SETTLE_TH;

  // FSM, frame counters, angle and power.
  // NOTE: every sequential assignment is non-blocking so all registers update
  // from pre-edge values; the async reset branch covers every register here.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_AIM;
      r_rot_cnt    <= '0;
      r_chg_cnt    <= '0;
      r_settle_cnt <= '0;
      r_angle      <= '0;
      r_power      <= '0;
    end else begin
      case (r_state)
        ST_AIM: if (startOfFrame) begin
          if (keyCharge && ballStopped) begin
            r_state   <= ST_CHARGE;
            r_power   <= '0;
            r_chg_cnt <= '0;
            r_rot_cnt <= '0;
          end else if (w_rot_one) begin
            if (r_rot_cnt == ROT_LAST) begin
              r_rot_cnt <= '0;
              // 5-bit arithmetic wraps 31+1 -> 0 and 0-1 -> 31 for free.
              r_angle   <= keyRotateCW ? r_angle + 5'd1 : r_angle - 5'd1;
            end else begin
              r_rot_cnt <= r_rot_cnt + 8'd1;
            end
          end else begin
            r_rot_cnt <= '0;
          end
        end
        ST_CHARGE: if (startOfFrame) begin
          if (keyCharge) begin
            if (r_chg_cnt == CHG_LAST) begin
              r_chg_cnt <= '0;
              if (r_power != PWR_MAX) r_power <= r_power + 6'd1;
            end else begin
              r_chg_cnt <= r_chg_cnt + 8'd1;
            end
          end else if (r_power == 6'd0) begin
            r_state <= ST_AIM;
          end else begin
            r_state <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          r_state      <= ST_WAIT_MOVE;
          r_settle_cnt <= '0;
        end
        ST_WAIT_MOVE: if (startOfFrame) begin
          if (w_settled && ballStopped) begin
            r_state <= ST_AIM;
            r_power <= '0;
          end else if (r_settle_cnt != 8'hFF) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end
        default: r_state <= ST_AIM;
      endcase
    end
  end

  // Shot velocity latch: captured on the release frame, held until the next shot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_vel_x <= '0;
      r_vel_y <= '0;
    end else if (w_fire_go) begin
      // Dropping the low bits of a signed value is an arithmetic shift (floor).
      r_vel_x <= w_prod_x[PROD_W-1:VEL_SHIFT];
      r_vel_y <= w_prod_y[PROD_W-1:VEL_SHIFT];
    end
  end

  assign velocityWriteEnable = (r_state == ST_FIRE);
  assign cueVisible          = (r_state == ST_AIM) || (r_state == ST_CHARGE);
  assign outVelocityX        = r_vel_x;
  assign outVelocityY        = r_vel_y;
  assign cueAngle            = r_angle;
  assign cuePower            = r_power;

endmodule

// File: tb/tb_cue_strike_controller.sv
// Bench for cue_strike_controller: directed scenarios with literal expected
// values, plus a random key sequence checked against a frame-level model.
module tb_cue_strike_controller;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               sof = 1'b0;
  logic               cw = 1'b0;
  logic               ccw = 1'b0;
  logic               chg = 1'b0;
  logic               stopped = 1'b0;
  logic               velocityWriteEnable;
  logic signed [10:0] outVelocityX;
  logic signed [10:0] outVelocityY;
  logic [4:0]         cueAngle;
  logic [5:0]         cuePower;
  logic               cueVisible;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;

  cue_strike_controller dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (sof),
    .keyRotateCW         (cw),
    .keyRotateCCW        (ccw),
    .keyCharge           (chg),
    .ballStopped         (stopped),
    .velocityWriteEnable (velocityWriteEnable),
    .outVelocityX        (outVelocityX),
    .outVelocityY        (outVelocityY),
    .cueAngle            (cueAngle),
    .cuePower            (cuePower),
    .cueVisible          (cueVisible)
  );

  always #5 clk = ~clk;

  // Every clock spent with the strobe high counts as one strobe cycle.
  always @(negedge clk) if (velocityWriteEnable === 1'b1) strobe_cnt++;

  // ---------------- frame-level reference model ----------------
  typedef enum {M_AIM, M_CHARGE, M_FIRE, M_WAIT} mode_t;
  mode_t m_mode;
  int m_angle, m_power, m_rot, m_held, m_wait, m_strobes, m_vx, m_vy;

  function automatic int dir_comp(input int k, input bit is_y);
    real a, d;
    a = 2.0 * 3.14159265358979 * real'(k) / 32.0;
    d = 64.0 * (is_y ? $sin(a) : $cos(a));
    return $rtoi(d >= 0.0 ? d + 0.5 : d - 0.5);
  endfunction

  function automatic int shot_vel(input int p, input int d);
    return $rtoi($floor(real'(p * d) / 4.0));
  endfunction

  task automatic model_reset();
    m_mode = M_AIM; m_angle = 0; m_power = 0; m_rot = 0;
    m_held = 0; m_wait = 0; m_vx = 0; m_vy = 0;
  endtask

  task automatic model_frame(input bit a, input bit b, input bit c, input bit d);
    case (m_mode)
      M_FIRE: begin m_mode = M_WAIT; m_wait = 0; end
      M_AIM: begin
        if (c && d) begin
          m_mode = M_CHARGE; m_power = 0; m_held = 0; m_rot = 0;
        end else if (a != b) begin
          m_rot++;
          if (m_rot == 4) begin
            m_rot = 0;
            m_angle = (m_angle + (a ? 1 : 31)) % 32;
          end
        end else m_rot = 0;
      end
      M_CHARGE: begin
        if (c) begin
          m_held++;
          m_power = (m_held / 3 > 63) ? 63 : m_held / 3;
        end else if (m_power == 0) m_mode = M_AIM;
        else begin
          m_vx = shot_vel(m_power, dir_comp(m_angle, 1'b0));
          m_vy = shot_vel(m_power, dir_comp(m_angle, 1'b1));
          m_strobes++;
          m_mode = M_FIRE;
        end
      end
      M_WAIT: begin
        m_wait++;
        if (m_wait >= 2 && d) begin m_mode = M_AIM; m_power = 0; end
      end
      default: m_mode = M_AIM;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  // Drives one startOfFrame cycle from the current point; returns at the next negedge.
  task automatic pulse(input bit a, input bit b, input bit c, input bit d);
    cw = a; ccw = b; chg = c; stopped = d; sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    model_frame(a, b, c, d);
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
    if (m_mode == M_FIRE) begin m_mode = M_WAIT; m_wait = 0; end
    #1;
  endtask

  task automatic do_frame(input bit a, input bit b, input bit c, input bit d);
    pulse(a, b, c, d);
    gap();
  endtask

  task automatic apply_reset();
    resetN = 1'b0; sof = 1'b0; cw = 1'b0; ccw = 1'b0; chg = 1'b0; stopped = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    total++; if (velocityWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we_in_reset: got=%b want=0", velocityWriteEnable); end
    total++; if (cueVisible !== 1'b1) begin bad++; $display("FAIL reset_visible_in_reset: got=%b want=1", cueVisible); end
    apply_reset();
    do_frame(0, 0, 0, 0);
    total++; if (cueAngle !== 5'd0) begin bad++; $display("FAIL reset_angle: got=%0d want=0", cueAngle); end
    total++; if (cuePower !== 6'd0) begin bad++; $display("FAIL reset_power: got=%0d want=0", cuePower); end
    total++; if (cueVisible !== 1'b1) begin bad++; $display("FAIL reset_visible: got=%b want=1", cueVisible); end
    total++; if (velocityWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we: got=%b want=0", velocityWriteEnable); end
    total++; if (outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin bad++; $display("FAIL reset_vel: got=(%0d,%0d) want=(0,0)", outVelocityX, outVelocityY); end
  endtask

  task automatic test_rotate();
    apply_reset();
    repeat (3) do_frame(0, 1, 0, 1);
    total++; if (cueAngle !== 5'd0) begin bad++; $display("FAIL rotate_ccw_3: got=%0d want=0", cueAngle); end
    do_frame(0, 1, 0, 1);
    total++; if (cueAngle !== 5'd31) begin bad++; $display("FAIL rotate_ccw_wrap: got=%0d want=31", cueAngle); end
    repeat (32) do_frame(1, 0, 0, 1);
    total++; if (cueAngle !== 5'd7) begin bad++; $display("FAIL rotate_cw_32: got=%0d want=7", cueAngle); end
    repeat (10) do_frame(1, 1, 0, 1);
    total++; if (cueAngle !== 5'd7) begin bad++; $display("FAIL rotate_both: got=%0d want=7", cueAngle); end
    // An idle frame between partial holds must restart the count.
    repeat (3) do_frame(1, 0, 0, 1);
    do_frame(0, 0, 0, 1);
    repeat (3) do_frame(1, 0, 0, 1);
    total++; if (cueAngle !== 5'd7) begin bad++; $display("FAIL rotate_count_clear: got=%0d want=7", cueAngle); end
  endtask

  task automatic test_fire_basic();
    int base;
    apply_reset();
    do_frame(0, 0, 1, 1);
    repeat (30) do_frame(0, 0, 1, 1);
    total++; if (cuePower !== 6'd10) begin bad++; $display("FAIL fire_power: got=%0d want=10", cuePower); end
    base = strobe_cnt;
    pulse(0, 0, 0, 1);
    #1;
    total++; if (velocityWriteEnable !== 1'b1) begin bad++; $display("FAIL fire_strobe_high: got=%b want=1", velocityWriteEnable); end
    total++; if (outVelocityX !== 11'sd160 || outVelocityY !== 11'sd0) begin bad++; $display("FAIL fire_vel_a0: got=(%0d,%0d) want=(160,0)", outVelocityX, outVelocityY); end
    @(negedge clk); #1;
    total++; if (velocityWriteEnable !== 1'b0) begin bad++; $display("FAIL fire_strobe_low: got=%b want=0", velocityWriteEnable); end
    total++; if (cueVisible !== 1'b0) begin bad++; $display("FAIL fire_hidden: got=%b want=0", cueVisible); end
    gap();
    total++; if (strobe_cnt - base !== 1) begin bad++; $display("FAIL fire_one_strobe: got=%0d want=1", strobe_cnt - base); end
    total++; if (outVelocityX !== 11'sd160) begin bad++; $display("FAIL fire_vel_hold: got=%0d want=160", outVelocityX); end
  endtask

  task automatic test_angles();
    apply_reset();
    repeat (80) do_frame(1, 0, 0, 1);
    total++; if (cueAngle !== 5'd20) begin bad++; $display("FAIL angle20_reach: got=%0d want=20", cueAngle); end
    do_frame(0, 0, 1, 1);
    repeat (30) do_frame(0, 0, 1, 1);
    do_frame(0, 0, 0, 1);
    total++; if (outVelocityX !== -11'sd113 || outVelocityY !== -11'sd113) begin bad++; $display("FAIL angle20_vel: got=(%0d,%0d) want=(-113,-113)", outVelocityX, outVelocityY); end
    repeat (2) do_frame(0, 0, 0, 1);
    repeat (16) do_frame(0, 1, 0, 1);
    total++; if (cueAngle !== 5'd16) begin bad++; $display("FAIL angle16_reach: got=%0d want=16", cueAngle); end
    do_frame(0, 0, 1, 1);
    repeat (300) do_frame(0, 0, 1, 1);
    total++; if (cuePower !== 6'd63) begin bad++; $display("FAIL power_saturate: got=%0d want=63", cuePower); end
    do_frame(0, 0, 0, 1);
    total++; if (outVelocityX !== -11'sd1008 || outVelocityY !== 11'sd0) begin bad++; $display("FAIL angle16_vel: got=(%0d,%0d) want=(-1008,0)", outVelocityX, outVelocityY); end
  endtask

  task automatic test_not_stopped();
    int base;
    apply_reset();
    base = strobe_cnt;
    repeat (7) do_frame(0, 0, 1, 0);
    do_frame(0, 0, 0, 0);
    total++; if (cuePower !== 6'd0) begin bad++; $display("FAIL moving_no_charge: got=%0d want=0", cuePower); end
    total++; if (strobe_cnt - base !== 0) begin bad++; $display("FAIL moving_no_strobe: got=%0d want=0", strobe_cnt - base); end
    total++; if (cueVisible !== 1'b1) begin bad++; $display("FAIL moving_visible: got=%b want=1", cueVisible); end
  endtask

  task automatic test_settle();
    apply_reset();
    do_frame(0, 0, 1, 1);
    repeat (3) do_frame(0, 0, 1, 1);
    pulse(0, 0, 0, 1);
    // A frame pulse landing in the strobe cycle must not count toward settling.
    pulse(0, 0, 0, 1);
    gap();
    do_frame(0, 0, 0, 1);
    total++; if (cueVisible !== 1'b0) begin bad++; $display("FAIL settle_frame1: got=%b want=0", cueVisible); end
    total++; if (cuePower !== 6'd1) begin bad++; $display("FAIL settle_power_held: got=%0d want=1", cuePower); end
    do_frame(0, 0, 0, 1);
    total++; if (cueVisible !== 1'b1) begin bad++; $display("FAIL settle_frame2: got=%b want=1", cueVisible); end
    total++; if (cuePower !== 6'd0) begin bad++; $display("FAIL settle_power_clear: got=%0d want=0", cuePower); end
  endtask

  task automatic test_tap();
    int base;
    apply_reset();
    base = strobe_cnt;
    do_frame(0, 0, 1, 1);
    do_frame(1, 0, 1, 1);
    do_frame(0, 0, 0, 1);
    total++; if (strobe_cnt - base !== 0) begin bad++; $display("FAIL tap_no_strobe: got=%0d want=0", strobe_cnt - base); end
    total++; if (cueAngle !== 5'd0) begin bad++; $display("FAIL tap_no_rotate_in_charge: got=%0d want=0", cueAngle); end
    repeat (4) do_frame(1, 0, 0, 1);
    total++; if (cueAngle !== 5'd1) begin bad++; $display("FAIL tap_back_in_aim: got=%0d want=1", cueAngle); end
  endtask

  task automatic test_reset_mid_charge();
    int base;
    apply_reset();
    do_frame(0, 0, 1, 1);
    repeat (12) do_frame(0, 0, 1, 1);
    do_frame(0, 0, 0, 1);
    total++; if (outVelocityX !== 11'sd64) begin bad++; $display("FAIL pre_reset_vel: got=%0d want=64", outVelocityX); end
    repeat (2) do_frame(0, 0, 0, 1);
    repeat (8) do_frame(1, 0, 0, 1);
    do_frame(0, 0, 1, 1);
    repeat (9) do_frame(0, 0, 1, 1);
    total++; if (cuePower !== 6'd3) begin bad++; $display("FAIL pre_reset_power: got=%0d want=3", cuePower); end
    base = strobe_cnt;
    #2 resetN = 1'b0;
    model_reset();
    #1;
    total++; if (cuePower !== 6'd0 || cueAngle !== 5'd0) begin bad++; $display("FAIL midreset_regs: got power=%0d angle=%0d want 0,0", cuePower, cueAngle); end
    total++; if (cueVisible !== 1'b1 || velocityWriteEnable !== 1'b0) begin bad++; $display("FAIL midreset_ctrl: got vis=%b we=%b want 1,0", cueVisible, velocityWriteEnable); end
    total++; if (outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin bad++; $display("FAIL midreset_vel: got=(%0d,%0d) want=(0,0)", outVelocityX, outVelocityY); end
    chg = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (strobe_cnt - base !== 0) begin bad++; $display("FAIL midreset_no_strobe: got=%0d want=0", strobe_cnt - base); end
  endtask

  task automatic test_random();
    int base_model;
    apply_reset();
    base_model = strobe_cnt;
    m_strobes = 0;
    for (int i = 0; i < 500; i++) begin
      bit a, b, c, d;
      a = ($urandom_range(0, 99) < 40);
      b = ($urandom_range(0, 99) < 30);
      c = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 9) == 0) begin
        pulse(a, b, c, d);
        continue;
      end
      do_frame(a, b, c, d);
      total++; if (cueAngle !== 5'(m_angle)) begin bad++; $display("FAIL rnd_angle[%0d]: got=%0d want=%0d", i, cueAngle, m_angle); end
      total++; if (cuePower !== 6'(m_power)) begin bad++; $display("FAIL rnd_power[%0d]: got=%0d want=%0d", i, cuePower, m_power); end
      total++; if (cueVisible !== (m_mode == M_AIM || m_mode == M_CHARGE)) begin bad++; $display("FAIL rnd_visible[%0d]: got=%b", i, cueVisible); end
      total++; if (strobe_cnt - base_model !== m_strobes) begin bad++; $display("FAIL rnd_strobes[%0d]: got=%0d want=%0d", i, strobe_cnt - base_model, m_strobes); end
      total++; if (outVelocityX !== 11'(m_vx) || outVelocityY !== 11'(m_vy)) begin bad++; $display("FAIL rnd_vel[%0d]: got=(%0d,%0d) want=(%0d,%0d)", i, outVelocityX, outVelocityY, m_vx, m_vy); end
    end
  endtask

  initial begin
    model_reset();
    m_strobes = 0;
    test_reset();
    test_rotate();
    test_fire_basic();
    test_angles();
    test_not_stopped();
    test_settle();
    test_tap();
    test_reset_mid_charge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
